hall_odometer: RTL and testbench
================================

HALL_ODOMETER -- requirements
Module: hall_odometer

Interface
REQ-001 The block SHALL have parameter CLK_PER_US, default 50, meaning clk cycles per microsecond tick.
REQ-002 The block SHALL have parameter DEB_US, default 500, meaning the microseconds the hall level must stay stable before it is accepted.
REQ-003 The block SHALL have parameter STALL_US, default 500000, meaning the microseconds without a hall event before a stall is declared.
REQ-004 The block SHALL have port clk, input, 1 bit: the 50 MHz system clock; the design has one clock and all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port hall, input, 1 bit: raw, asynchronous hall sensor level.
REQ-007 The block SHALL have port clear, input, 1 bit: synchronous clear of all measurements.
REQ-008 The block SHALL have port count_en, input, 1 bit: enables pulse counting.
REQ-009 The block SHALL have port target_count, input, 16 bits: pulse count at which target_hit fires.
REQ-010 The block SHALL have port pulse_count, output, 16 bits: accepted hall events.
REQ-011 The block SHALL have port period_us, output, 20 bits: microseconds between the last two events.
REQ-012 The block SHALL have port period_valid, output, 1 bit: period_us holds a valid measurement.
REQ-013 The block SHALL have port stalled, output, 1 bit: no event seen for STALL_US.
REQ-014 The block SHALL have port hall_event, output, 1 bit: one-cycle pulse per accepted rising edge.
REQ-015 The block SHALL have port target_hit, output, 1 bit: one-cycle pulse when pulse_count becomes equal to target_count.

Function
REQ-016 hall SHALL pass through a 2-flop synchronizer before any other use.
REQ-017 A free-running prescaler SHALL count 0..CLK_PER_US-1 and assert us_tick for one clk when it wraps.
REQ-018 The debouncer SHALL be a four-state machine: LOW, CHK_HIGH, HIGH, CHK_LOW.
- In LOW with synced=1, it SHALL go to CHK_HIGH and zero the debounce counter.
- In CHK_HIGH with synced=0, it SHALL return to LOW.
- In CHK_HIGH, the debounce counter SHALL increment on each us_tick; on reaching DEB_US the machine SHALL go to HIGH.
- HIGH, CHK_LOW and the return to HIGH SHALL behave symmetrically.
REQ-019 hall_event SHALL pulse for exactly one clk on the cycle after the CHK_HIGH->HIGH transition; the CHK_LOW->LOW transition SHALL produce no event.
REQ-020 On hall_event with count_en=1, pulse_count SHALL increment by 1, saturating at 16'hFFFF with no wrap; with count_en=0, pulse_count SHALL hold.
REQ-021 An interval timer SHALL increment on us_tick, saturating at 20'hFFFFF.
REQ-022 On hall_event, the interval timer SHALL reset to 0, regardless of count_en.
REQ-023 On hall_event, if a previous event exists since reset or clear:
- period_us SHALL load the timer value;
- period_valid SHALL be set.
REQ-024 On the first event after reset or clear, period_us and period_valid SHALL be unchanged; only the previous-event flag SHALL be set.
REQ-025 When the timer reaches STALL_US, stalled SHALL be set and period_valid cleared; period_us SHALL hold its last value.
REQ-026 stalled SHALL clear on the next hall_event. That event counts as a first event (REQ-024): period_valid stays 0 until the following event.
REQ-027 target_hit SHALL pulse for one clk on the cycle after pulse_count changes to a value equal to target_count.
- target_count=0 SHALL never fire.
- A saturated count that holds SHALL not re-fire.
REQ-028 clear=1 SHALL, on the next edge, zero pulse_count, period_us, the timer and the previous-event flag, and deassert period_valid, stalled and target_hit. The debouncer state SHALL be kept.
REQ-029 If clear and hall_event coincide, clear SHALL take priority and the event SHALL not be counted or timed; hall_event itself SHALL still be output.
REQ-030 Total latency from a clean hall rise to hall_event SHALL be 2 sync clk + DEB_US us (+ at most one prescaler period) + 1 clk.

Reset
REQ-031 While rst=1 at a clk edge:
- pulse_count, period_us and the timer SHALL be 0;
- period_valid, stalled, hall_event and target_hit SHALL be 0;
- the debouncer SHALL be in LOW;
- the prescaler, debounce counter and previous-event flag SHALL be 0.
REQ-032 rst SHALL override clear and all events, including mid-debounce and mid-period.

Verification
REQ-033 Glitch rejection: with DEB_US=500, a 300 us high glitch, then a 600 us high pulse -> exactly one hall_event, about 500 us after the second rise; pulse_count=1.
REQ-034 Period: count_en=1, clean edges 10000 us apart -> after the 2nd event, period_us=10000 ±1 and period_valid=1; after the 1st event, period_valid=0.
REQ-035 Stall: after 2 events, hold hall static for 500000 us -> stalled=1 and period_valid=0. The next event clears stalled, with period_valid still 0; the event after that sets period_valid=1.
REQ-036 Target and saturation:
- target_count=3 -> target_hit exactly once, on the 3rd event.
- Preload to 16'hFFFE, then 3 events -> pulse_count stays 16'hFFFF with no wrap.
REQ-037 Clear collision: assert clear on the same cycle as hall_event -> pulse_count=0, period_valid=0, and the next event is treated as a first event.
REQ-038 Reset mid-operation: rst pulsed in CHK_HIGH with pulse_count=5 -> all outputs 0, debouncer in LOW, and no hall_event from the interrupted edge.

Source files
------------

// File: rtl/hall_odometer.sv
// Hall-sensor odometer: synchronizes and debounces a raw hall level, counts
// accepted rising edges, measures the interval between them and flags stalls.
module hall_odometer #(
    parameter int CLK_PER_US = 50,
    parameter int DEB_US     = 500,
    parameter int STALL_US   = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hall,
    input  logic        clear,
    input  logic        count_en,
    input  logic [15:0] target_count,
    output logic [15:0] pulse_count,
    output logic [19:0] period_us,
    output logic        period_valid,
    output logic        stalled,
    output logic        hall_event,
    output logic        target_hit
);

    localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam int DW = (DEB_US > 0) ? $clog2(DEB_US + 1) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_US - 1);
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_US);
    localparam logic [19:0]   STALL_LIM = 20'(STALL_US);
    localparam logic [19:0]   TIMER_SAT = 20'hFFFFF;
    localparam logic [15:0]   COUNT_SAT = 16'hFFFF;

    typedef enum logic [1:0] {
        LOW,
        CHK_HIGH,
        HIGH,
        CHK_LOW
    } deb_state_e;

    logic            sync1_q, sync2_q;
    logic [PW-1:0]   presc_q, presc_d;
    logic            us_tick;
    deb_state_e      state_q, state_d;
    logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
    logic [DW-1:0]   deb_inc;
    logic            rise_d;
    logic            hall_event_q;

    logic [15:0]     pulse_count_q, pulse_count_d;
    logic [19:0]     timer_q, timer_d;
    logic [19:0]     period_q, period_d;
    logic            valid_q, valid_d;
    logic            stalled_q, stalled_d;
    logic            prev_q, prev_d;
    logic            target_hit_q, target_hit_d;

    // Free-running microsecond prescaler.
    assign us_tick = (presc_q == PRESC_MAX);
    assign presc_d = us_tick ? '0 : presc_q + 1'b1;
    assign deb_inc = deb_cnt_q + 1'b1;

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        case (state_q)
            LOW: begin
                if (sync2_q) begin
                    state_d   = CHK_HIGH;
                    deb_cnt_d = '0;
                end
            end
            CHK_HIGH: begin
                if (!sync2_q) begin
                    state_d = LOW;
                end else if (us_tick) begin
                    deb_cnt_d = deb_inc;
                    if (deb_inc == DEB_MAX) state_d = HIGH;
                end
            end
            HIGH: begin
                if (!sync2_q) begin
                    state_d   = CHK_LOW;
                    deb_cnt_d = '0;
                end
            end
            CHK_LOW: begin
                if (sync2_q) begin
                    state_d = HIGH;
                end else if (us_tick) begin
                    deb_cnt_d = deb_inc;
                    if (deb_inc == DEB_MAX) state_d = LOW;
                end
            end
            default: state_d = LOW;
        endcase
    end

    // Only an accepted rising level is an event; the falling side is silent.
    assign rise_d = (state_q == CHK_HIGH) && (state_d == HIGH);

    always_comb begin
        pulse_count_d = pulse_count_q;
        timer_d       = timer_q;
        period_d      = period_q;
        valid_d       = valid_q;
        stalled_d     = stalled_q;
        prev_d        = prev_q;

        if (us_tick && (timer_q != TIMER_SAT)) timer_d = timer_q + 1'b1;

        if (clear) begin
            pulse_count_d = '0;
            timer_d       = '0;
            period_d      = '0;
            valid_d       = 1'b0;
            stalled_d     = 1'b0;
            prev_d        = 1'b0;
        end else if (hall_event_q) begin
            timer_d   = '0;
            stalled_d = 1'b0;
            prev_d    = 1'b1;
            if (count_en && (pulse_count_q != COUNT_SAT)) pulse_count_d = pulse_count_q + 1'b1;
            if (prev_q) begin
                period_d = timer_q;
                valid_d  = 1'b1;
            end
        end else if (timer_q >= STALL_LIM) begin
            // Dropping the previous-event flag makes the next event a first event.
            stalled_d = 1'b1;
            valid_d   = 1'b0;
            prev_d    = 1'b0;
        end

        target_hit_d = !clear && (pulse_count_d != pulse_count_q) &&
                       (pulse_count_d == target_count) && (target_count != 16'h0);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            presc_q       <= '0;
            state_q       <= LOW;
            deb_cnt_q     <= '0;
            hall_event_q  <= 1'b0;
            pulse_count_q <= '0;
            timer_q       <= '0;
            period_q      <= '0;
            valid_q       <= 1'b0;
            stalled_q     <= 1'b0;
            prev_q        <= 1'b0;
            target_hit_q  <= 1'b0;
        end else begin
            sync1_q       <= hall;
            sync2_q       <= sync1_q;
            presc_q       <= presc_d;
            state_q       <= state_d;
            deb_cnt_q     <= deb_cnt_d;
            hall_event_q  <= rise_d;
            pulse_count_q <= pulse_count_d;
            timer_q       <= timer_d;
            period_q      <= period_d;
            valid_q       <= valid_d;
            stalled_q     <= stalled_d;
            prev_q        <= prev_d;
            target_hit_q  <= target_hit_d;
        end
    end

    assign pulse_count  = pulse_count_q;
    assign period_us    = period_q;
    assign period_valid = valid_q;
    assign stalled      = stalled_q;
    assign hall_event   = hall_event_q;
    assign target_hit   = target_hit_q;

endmodule

// File: tb/tb_hall_odometer.sv
// Scoreboard bench for hall_odometer: each accepted hall pulse pushes its
// expected measurement, which is compared on the cycle after hall_event.
module tb_hall_odometer;

    localparam int CPU   = 2;
    localparam int DEB   = 20;
    localparam int STALL = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hall = 1'b0;
    logic        clear = 1'b0;
    logic        count_en = 1'b0;
    logic [15:0] target_count = 16'h0;
    logic [15:0] pulse_count;
    logic [19:0] period_us;
    logic        period_valid;
    logic        stalled;
    logic        hall_event;
    logic        target_hit;

    hall_odometer #(
        .CLK_PER_US(CPU),
        .DEB_US    (DEB),
        .STALL_US  (STALL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hall        (hall),
        .clear       (clear),
        .count_en    (count_en),
        .target_count(target_count),
        .pulse_count (pulse_count),
        .period_us   (period_us),
        .period_valid(period_valid),
        .stalled     (stalled),
        .hall_event  (hall_event),
        .target_hit  (target_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] count;
        logic        valid;
        logic [19:0] period;
        logic        hit;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          last_ev = 0;
    int          th_cnt = 0;
    int          rise_cyc;
    int          k;

    logic [15:0] m_count = 16'h0;
    bit          m_prev = 1'b0;
    bit          m_valid = 1'b0;
    logic [19:0] m_period = 20'h0;
    int          m_last_rise = 0;

    task automatic check(input string tag, input longint obs, input longint exp, input longint tol = 0);
        n_checks++;
        if ((obs > exp + tol) || (obs < exp - tol)) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic model_clear();
        m_count  = 16'h0;
        m_prev   = 1'b0;
        m_valid  = 1'b0;
        m_period = 20'h0;
    endtask

    task automatic push_event(input int rise);
        exp_t e;
        bit   changed;
        changed = 1'b0;
        if (count_en && (m_count != 16'hFFFF)) begin
            m_count = m_count + 16'd1;
            changed = 1'b1;
        end
        if (m_prev) begin
            m_valid  = 1'b1;
            m_period = 20'((rise - m_last_rise) / CPU);
        end
        m_prev      = 1'b1;
        m_last_rise = rise;
        e.count  = m_count;
        e.valid  = m_valid;
        e.period = m_period;
        e.hit    = changed && (m_count == target_count) && (target_count != 16'h0);
        sb_q.push_back(e);
    endtask

    task automatic pulse(input int high_us, input int low_us, input bit accepted);
        if (accepted) push_event(cyc);
        hall = 1'b1;
        repeat (high_us * CPU) @(negedge clk);
        hall = 1'b0;
        repeat (low_us * CPU) @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_clear();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_count"}, pulse_count, 0);
        check({tag, "_period"}, period_us, 0);
        check({tag, "_valid"}, period_valid, 0);
        check({tag, "_stalled"}, stalled, 0);
        check({tag, "_event"}, hall_event, 0);
        check({tag, "_hit"}, target_hit, 0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (target_hit === 1'b1) th_cnt++;

    // Monitor: measurements are valid on the cycle after hall_event.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (hall_event === 1'b1) begin
                last_ev = cyc;
                @(negedge clk);
                if (sb_q.size() == 0) begin
                    check("unexpected_event", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("ev_count", pulse_count, e.count);
                    check("ev_valid", period_valid, e.valid);
                    if (e.valid) check("ev_period", period_us, e.period, 1);
                    check("ev_target_hit", target_hit, e.hit);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        count_en = 1'b1;

        // Short glitch rejected, long pulse accepted after the debounce time.
        pulse(12, 30, 1'b0);
        rise_cyc = cyc;
        pulse(24, 30, 1'b1);
        check("deb_latency", last_ev - rise_cyc, DEB * CPU + 4, 4);
        check("glitch_count", pulse_count, 1);

        do_clear();
        check("clear_count", pulse_count, 0);
        check("clear_valid", period_valid, 0);

        // Period between two clean edges 200 us apart.
        pulse(100, 100, 1'b1);
        pulse(100, 100, 1'b1);
        check("period_value", period_us, 200, 1);
        check("period_valid", period_valid, 1);

        // Stall, then recovery through a first event.
        repeat ((STALL + 50) * CPU) @(negedge clk);
        m_prev  = 1'b0;
        m_valid = 1'b0;
        check("stall_set", stalled, 1);
        check("stall_valid", period_valid, 0);
        check("stall_period_hold", period_us, m_period, 1);
        pulse(100, 100, 1'b1);
        check("stall_clear", stalled, 0);
        pulse(100, 100, 1'b1);

        // target_count=0 never fires; target 3 fires once.
        do_clear();
        check("target0_no_hit", th_cnt, 0);
        th_cnt = 0;
        target_count = 16'd3;
        repeat (4) pulse(100, 100, 1'b1);
        check("target_hit_once", th_cnt, 1);

        count_en = 1'b0;
        pulse(100, 100, 1'b1);
        check("count_en_hold", pulse_count, 4);
        count_en = 1'b1;

        // Saturation from a preloaded 16'hFFFE; target FFFF fires only once.
        target_count = 16'hFFFF;
        force dut.pulse_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.pulse_count_q;
        @(negedge clk);
        m_count = 16'hFFFE;
        th_cnt  = 0;
        check("preload", pulse_count, 16'hFFFE);
        repeat (3) pulse(100, 100, 1'b1);
        check("sat_count", pulse_count, 16'hFFFF);
        check("sat_hit_once", th_cnt, 1);
        target_count = 16'h0;

        // Clear on the same cycle as hall_event.
        sb_q.push_back('{count: 16'h0, valid: 1'b0, period: 20'h0, hit: 1'b0});
        hall = 1'b1;
        k = 0;
        while ((hall_event !== 1'b1) && (k < 200)) begin
            @(negedge clk);
            k++;
        end
        check("collision_seen", hall_event, 1);
        clear = 1'b1;
        model_clear();
        @(negedge clk);
        clear = 1'b0;
        check("collision_count", pulse_count, 0);
        check("collision_valid", period_valid, 0);
        repeat (100 * CPU) @(negedge clk);
        hall = 1'b0;
        repeat (100 * CPU) @(negedge clk);
        pulse(100, 100, 1'b1);
        pulse(100, 100, 1'b1);
        repeat (3) pulse(100, 100, 1'b1);
        check("pre_reset_count", pulse_count, 5);

        // Reset in the middle of a debounce.
        hall = 1'b1;
        repeat (20) @(negedge clk);
        rst  = 1'b1;
        hall = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("midrst");
        check("midrst_deb_low", dut.state_q, 0);
        rst = 1'b0;
        model_clear();
        repeat (DEB * CPU * 3) @(negedge clk);
        check_all_zero("post_rst");

        check("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
